addr_gen_ext: RTL

Parametrised, handshaked address generator for the memory checker test engine, replacing the fixed-width, free-running address source. It produces exactly `addr_cnt_i` addresses per test over a valid/ready interface, then signals completion. It adds DEC mode, a bounded base/limit window with stride, and a seedable LFSR of arbitrary width. It sits between the CSR block, which supplies the configuration, and the transaction generator, which consumes the addresses.

---
 rtl/addr_gen_ext.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/addr_gen_ext.sv
// addr_gen_ext: handshaked address generator for the memory checker test engine.
// Issues exactly addr_cnt_i addresses over a valid/ready interface, then pulses
// done_o. Supported modes: FIX, RND (Fibonacci LFSR), RUN_0, RUN_1, INC and DEC.
// INC and DEC walk a base/limit window with a stride.
//
// Ports
//   clk_i, rst_n_i   clock; asynchronous active-low reset
//   start_i          one-cycle start pulse, honoured in IDLE only
//   abort_i          stops a running test
//   mode_i           0 FIX, 1 RND, 2 RUN_0, 3 RUN_1, 4 INC, 5 DEC (6/7 invalid)
//   base_addr_i      FIX address; INC/DEC lower bound (inclusive)
//   limit_addr_i     INC/DEC upper bound (inclusive)
//   step_i           INC/DEC stride (0 is treated as 1)
//   seed_i           LFSR seed (0 is treated as all-ones)
//   addr_cnt_i       number of addresses to issue
//   addr_o / addr_valid_o / addr_ready_i   address stream
//   busy_o           high while running
//   done_o           one-cycle completion pulse
//   err_o            config error, held until the next accepted start
module addr_gen_ext #(
  parameter int                ADDR_W    = 24,
  parameter int                CNT_W     = 32,
  parameter int                STEP_W    = 8,
  parameter logic [ADDR_W-1:0] LFSR_TAPS = ADDR_W'(24'hE10000)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [2:0]        mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] limit_addr_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [ADDR_W-1:0] seed_i,
  input  logic [CNT_W-1:0]  addr_cnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // Window arithmetic needs one carry bit beyond the wider of address and stride.
  localparam int SUM_W = ((ADDR_W > STEP_W) ? ADDR_W : STEP_W) + 1;

  localparam logic [2:0] M_FIX  = 3'd0;
  localparam logic [2:0] M_RND  = 3'd1;
  localparam logic [2:0] M_RUN0 = 3'd2;
  localparam logic [2:0] M_RUN1 = 3'd3;
  localparam logic [2:0] M_INC  = 3'd4;
  localparam logic [2:0] M_DEC  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   limit_q, limit_d;
  logic [SUM_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   lfsr_q, lfsr_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Config decode on the raw inputs (used only at start)
  logic [SUM_W-1:0]    step_eff;
  logic [ADDR_W-1:0]   seed_eff;
  logic [ADDR_W-1:0]   first_addr;
  logic                cfg_bad;

  // Next-address datapath on the latched config
  logic [SUM_W-1:0]    inc_sum;
  logic [SUM_W-1:0]    dec_floor;
  logic [ADDR_W-1:0]   lfsr_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic                acc;

  always_comb begin
    step_eff = (step_i == '0) ? SUM_W'(1) : SUM_W'(step_i);
    seed_eff = (seed_i == '0) ? '1 : seed_i;
    cfg_bad  = (mode_i > M_DEC) ||
               (((mode_i == M_INC) || (mode_i == M_DEC)) && (base_addr_i > limit_addr_i));
    case (mode_i)
      M_RND:   first_addr = seed_eff;
      M_RUN0:  first_addr = ~ADDR_W'(1);
      M_RUN1:  first_addr = ADDR_W'(1);
      M_DEC:   first_addr = limit_addr_i;
      default: first_addr = base_addr_i;
    endcase
  end

  always_comb begin
    inc_sum   = SUM_W'(addr_q) + step_q;
    dec_floor = SUM_W'(base_q) + step_q;
    lfsr_nx   = {lfsr_q[ADDR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    case (mode_q)
      M_RND:   addr_nx = lfsr_nx;
      M_RUN0,
      M_RUN1:  addr_nx = {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]};
      M_INC:   addr_nx = (inc_sum > SUM_W'(limit_q)) ? base_q : inc_sum[ADDR_W-1:0];
      // addr >= base+step here, so the stride fits in ADDR_W bits
      M_DEC:   addr_nx = (SUM_W'(addr_q) < dec_floor) ? limit_q
                                                      : addr_q - step_q[ADDR_W-1:0];
      default: addr_nx = base_q;
    endcase
  end

  assign acc = vld_q & addr_ready_i;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    limit_d = limit_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          base_d  = base_addr_i;
          limit_d = limit_addr_i;
          step_d  = step_eff;
          cnt_d   = addr_cnt_i;
          err_d   = cfg_bad;
          if (cfg_bad || (addr_cnt_i == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            vld_d   = 1'b1;
            busy_d  = 1'b1;
            addr_d  = first_addr;
            if (mode_i == M_RND) lfsr_d = seed_eff;
          end
        end
      end
      S_RUN: begin
        if (acc) begin
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = addr_nx;
          if (mode_q == M_RND) lfsr_d = lfsr_nx;
        end
        // A beat accepted alongside abort still counts as delivered
        if (abort_i || (acc && (cnt_q == CNT_W'(1)))) begin
          state_d = S_DONE;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      mode_q  <= M_FIX;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= SUM_W'(1);
      cnt_q   <= '0;
      addr_q  <= '0;
      lfsr_q  <= '1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lfsr_q  <= lfsr_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = vld_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
